// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register file.
// Used by register_file and regfile_rdport.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       reg_data_t;
endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: x0 forced to zero, optional same-cycle write forwarding.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  raddr,
`ifdef REGFILE_BYPASS_EN
  input  logic                               resetn,
  input  logic                               regwrite,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
`endif
  output logic [DATA_W-1:0]                  rdata
);

  always_comb begin
    rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
    // A pending reset wins over forwarding, matching what the edge will store.
    if (regwrite && !resetn && (waddr != '0) && (waddr == raddr))
      rdata = wdata;
`endif
    if (raddr == '0)
      rdata = '0;
  end

endmodule

// File: rtl/register_file.sv
// Register file: NREGS x DATA_W storage, one write port, two read ports, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;

  // resetn is active-high here: 1 clears everything and drops any concurrent write.
  always_ff @(posedge clk) begin
    if (resetn)
      regs <= '0;
    else if (regwrite && (waddr != '0))
      regs[waddr] <= wdata;
  end

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
    .regs     (regs),
    .raddr    (raddr1),
`ifdef REGFILE_BYPASS_EN
    .resetn   (resetn),
    .regwrite (regwrite),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .rdata    (rdata1)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
    .regs     (regs),
    .raddr    (raddr2),
`ifdef REGFILE_BYPASS_EN
    .resetn   (resetn),
    .regwrite (regwrite),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// against an array model of the 32 registers.
module tb_register_file;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        regwrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  register_file dut (
    .clk      (clk),
    .resetn   (resetn),
    .regwrite (regwrite),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2)
  );

  always #5 clk = ~clk;

  // Value a read port should show right now, given stored state and the pending write.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (regwrite && !resetn && waddr != 5'd0 && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  // One rising edge; the model takes the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (resetn) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (regwrite && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1; regwrite = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0;
    tick();
    resetn = 1'b0; raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_r1r2: got %h %h expected 0 0", rdata1, rdata2);
    end
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0]; raddr2 = 5'(31 - a);
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_all addr %0d: got %h %h expected 0 0", a, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    regwrite = 1'b1; waddr = 5'd1; wdata = 32'hAAAA_AAAA;
    tick();
    regwrite = 1'b0; raddr1 = 5'd1; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'hAAAA_AAAA || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL write_read: got %h %h expected aaaaaaaa 0", rdata1, rdata2);
    end
    regwrite = 1'b1; waddr = 5'd2; wdata = 32'h5555_5555;
    tick();
    regwrite = 1'b0; raddr1 = 5'd2; raddr2 = 5'd1;
    #1;
    checks++;
    if (rdata1 !== 32'h5555_5555 || rdata2 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL second_write: got %h %h expected 55555555 aaaaaaaa", rdata1, rdata2);
    end
    // regwrite low must not store
    waddr = 5'd1; wdata = 32'h0BAD_F00D;
    tick();
    raddr1 = 5'd1; raddr2 = 5'd1;
    #1;
    checks++;
    if (rdata1 !== 32'hAAAA_AAAA || rdata2 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL no_write_hold: got %h %h expected aaaaaaaa aaaaaaaa", rdata1, rdata2);
    end
  endtask

  task automatic test_x0();
    regwrite = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_pre_edge: got %h %h expected 0 0", rdata1, rdata2);
    end
    tick();
    regwrite = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_write: got %h %h expected 0 0", rdata1, rdata2);
    end
  endtask

  task automatic test_reset_vs_write();
    resetn = 1'b1; regwrite = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    raddr1 = 5'd1;
    #1;
    checks++;
    if (rdata1 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL reset_hold_until_edge: got %h expected aaaaaaaa", rdata1);
    end
    tick();
    resetn = 1'b0; regwrite = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_vs_write: got %h %h expected 0 0", rdata1, rdata2);
    end
    raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_vs_write_others: got %h %h expected 0 0", rdata1, rdata2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] pre;
`ifdef REGFILE_BYPASS_EN
    pre = 32'hDEAD_BEEF;
`else
    pre = 32'h0;
`endif
    regwrite = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd4;
    #1;
    checks++;
    if (rdata1 !== pre || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL bypass_pre_edge: got %h %h expected %h 0", rdata1, rdata2, pre);
    end
    tick();
    regwrite = 1'b0; raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_post_edge: got %h %h expected deadbeef deadbeef", rdata1, rdata2);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      resetn   = ($urandom_range(0, 39) == 0);
      regwrite = $urandom_range(0, 1);
      waddr    = 5'($urandom_range(0, 31));
      wdata    = $urandom;
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2   = ($urandom_range(0, 5) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_read(raddr1);
      e2 = exp_read(raddr2);
      checks++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        errors++;
        $display("FAIL random[%0d] ra1=%0d ra2=%0d: got %h %h expected %h %h",
                 n, raddr1, raddr2, rdata1, rdata2, e1, e2);
      end
      tick();
    end
    resetn = 1'b0; regwrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    resetn = 1'b1; regwrite = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_x0();
    test_reset_vs_write();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
